mem_stall_ctrl: RTL and testbench



---
 rtl/rv32i_types.sv | 40 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/mem_stall_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared RV32I type definitions: base opcodes, the per-stage control word
// carried down the pipeline, and the stall-controller state classification.
// Ports: none (package).
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic        regfile_wr;
        logic [4:0]  rd;
    } rv32i_control_word;

    // Registered classification of a pipeline cycle.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EXT_WAIT = 2'd2
    } stall_state_t;

    function automatic logic is_mem_op(input rv32i_opcode op);
        return (op == op_load) || (op == op_store);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   i_clk   - clock
//   i_clr_n - synchronous active-low clear (priority over increment)
//   i_inc   - increment enable
//   o_cnt   - current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
// Pipeline hazard/stall controller. Turns I-cache / D-cache handshakes and
// multi-cycle-unit busy flags into per-pipeline-register load enables, bubble
// inserts and PC hold. A response that arrives while the other port (or an
// external unit) is still busy is captured in a sticky flag so the request is
// not reissued. Also keeps saturating stall-cycle counters and a memory
// watchdog.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   imem_resp_i         - instruction-cache response
//   dmem_resp_i         - data-cache response
//   ex_mem_ctrl_word_i  - control word of the instruction in MEM
//   ext_stall_i         - multi-cycle unit busy flags
//   preg_ld_o           - per-register load enable (0 = IF/ID)
//   preg_bubble_o       - per-register NOP insert (bit 0 always 0)
//   pc_ld_o             - PC load enable
//   imem_read_o         - instruction-cache read request
//   dmem_read_o         - data-cache read request
//   dmem_write_o        - data-cache write request
//   mem_stall_cnt_o     - cycles stalled on memory (saturating)
//   ext_stall_cnt_o     - cycles stalled on external units only (saturating)
//   mem_timeout_o       - sticky watchdog flag
// -----------------------------------------------------------------------------
module mem_stall_ctrl
    import rv32i_types::*;
#(
    parameter int NUM_PREGS = 4,
    parameter int EXT_IDX   = 2,
    parameter int NUM_EXT   = 2,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_resp_i,
    input  logic                 dmem_resp_i,
    input  rv32i_control_word    ex_mem_ctrl_word_i,
    input  logic [NUM_EXT-1:0]   ext_stall_i,
    output logic [NUM_PREGS-1:0] preg_ld_o,
    output logic [NUM_PREGS-1:0] preg_bubble_o,
    output logic                 pc_ld_o,
    output logic                 imem_read_o,
    output logic                 dmem_read_o,
    output logic                 dmem_write_o,
    output logic [CNT_W-1:0]     mem_stall_cnt_o,
    output logic [CNT_W-1:0]     ext_stall_cnt_o,
    output logic                 mem_timeout_o
);

    localparam int             WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic                 w_mem_access;
    logic                 w_is_load;
    logic                 w_is_store;
    logic                 w_imem_done;
    logic                 w_dmem_done;
    logic                 w_mem_hold;
    logic                 w_ext_hold;
    logic                 w_advance;
    logic [NUM_PREGS-1:0] w_hold;

    logic                 r_i_seen;
    logic                 r_d_seen;

    stall_state_t         r_state;
    stall_state_t         w_state_nxt;

    logic                 w_in_mem_wait;
    logic                 w_in_ext_wait;
    logic [WD_W-1:0]      w_wd_cnt;
    logic                 w_wd_hit;
    logic                 r_timeout;

    // Only the opcode matters here; the rest of the control word passes by.
    logic                 w_unused_cw;
    assign w_unused_cw = ^{ex_mem_ctrl_word_i.funct3,
                           ex_mem_ctrl_word_i.regfile_wr,
                           ex_mem_ctrl_word_i.rd};

    assign w_is_load    = (ex_mem_ctrl_word_i.opcode == op_load);
    assign w_is_store   = (ex_mem_ctrl_word_i.opcode == op_store);
    assign w_mem_access = is_mem_op(ex_mem_ctrl_word_i.opcode);

    // A port counts as done if it responds now or already responded during
    // this stall; a non-memory instruction never waits on the D-cache.
    assign w_imem_done = imem_resp_i | r_i_seen;
    assign w_dmem_done = ~w_mem_access | dmem_resp_i | r_d_seen;
    assign w_mem_hold  = ~w_imem_done | ~w_dmem_done;
    assign w_ext_hold  = |ext_stall_i;
    assign w_advance   = ~w_mem_hold & ~w_ext_hold;

    // Memory stalls freeze everything; an external stall freezes only the
    // front of the pipe up to EX/MEM so older instructions can drain.
    always_comb begin
        w_hold = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            w_hold[i] = w_mem_hold | (w_ext_hold & (i <= EXT_IDX));
        end
    end

    always_comb begin
        preg_ld_o     = '0;
        preg_bubble_o = '0;
        pc_ld_o       = 1'b0;
        imem_read_o   = 1'b0;
        dmem_read_o   = 1'b0;
        dmem_write_o  = 1'b0;
        if (rst_n) begin
            preg_ld_o = ~w_hold;
            // A register that loads while its upstream neighbour is frozen
            // would duplicate that instruction; load a NOP instead.
            for (int i = 1; i < NUM_PREGS; i++) begin
                preg_bubble_o[i] = ~w_hold[i] & w_hold[i-1];
            end
            pc_ld_o      = ~w_hold[0];
            imem_read_o  = ~r_i_seen;
            dmem_read_o  = w_is_load  & ~r_d_seen;
            dmem_write_o = w_is_store & ~r_d_seen;
        end
    end

    // Sticky response capture: clear wins over set so a response in the
    // advancing cycle is consumed rather than carried into the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_seen <= 1'b0;
            r_d_seen <= 1'b0;
        end else if (w_advance) begin
            r_i_seen <= 1'b0;
            r_d_seen <= 1'b0;
        end else begin
            if (imem_resp_i) begin
                r_i_seen <= 1'b1;
            end
            if (dmem_resp_i && w_mem_access) begin
                r_d_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = RUN;
        if (w_mem_hold) begin
            w_state_nxt = MEM_WAIT;
        end else if (w_ext_hold) begin
            w_state_nxt = EXT_WAIT;
        end
    end

    assign w_in_mem_wait = (r_state == MEM_WAIT);
    assign w_in_ext_wait = (r_state == EXT_WAIT);

    sat_counter #(.W(CNT_W)) u_mem_cnt (
        .i_clk   (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_in_mem_wait),
        .o_cnt   (mem_stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_ext_cnt (
        .i_clk   (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_in_ext_wait),
        .o_cnt   (ext_stall_cnt_o)
    );

    // Consecutive-wait counter: any non-memory-wait cycle restarts it.
    sat_counter #(.W(WD_W)) u_wd_cnt (
        .i_clk   (clk),
        .i_clr_n (rst_n & w_in_mem_wait),
        .i_inc   (w_in_mem_wait),
        .o_cnt   (w_wd_cnt)
    );

    assign w_wd_hit = (w_wd_cnt == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_wd_hit) begin
            r_timeout <= 1'b1;
        end
    end

    // Flag is visible in the same cycle the limit is reached, then held.
    assign mem_timeout_o = r_timeout | w_wd_hit;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
module tb_mem_stall_ctrl;
    import rv32i_types::*;

    localparam int NP      = 4;
    localparam int EXT_IDX = 2;
    localparam int NEXT    = 2;
    localparam int CW      = 6;
    localparam int TO      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int WD_MAX  = (1 << $clog2(TO + 1)) - 1;
    localparam logic [NP-1:0] FRONT_MASK = NP'((1 << (EXT_IDX + 1)) - 1);

    logic              clk;
    logic              rst_n;
    logic              imem_resp;
    logic              dmem_resp;
    rv32i_control_word cw;
    logic [NEXT-1:0]   ext_stall;
    logic [NP-1:0]     preg_ld;
    logic [NP-1:0]     preg_bubble;
    logic              pc_ld;
    logic              imem_read;
    logic              dmem_read;
    logic              dmem_write;
    logic [CW-1:0]     mem_cnt;
    logic [CW-1:0]     ext_cnt;
    logic              mem_timeout;

    mem_stall_ctrl #(
        .NUM_PREGS (NP),
        .EXT_IDX   (EXT_IDX),
        .NUM_EXT   (NEXT),
        .CNT_W     (CW),
        .TIMEOUT   (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem_resp_i        (imem_resp),
        .dmem_resp_i        (dmem_resp),
        .ex_mem_ctrl_word_i (cw),
        .ext_stall_i        (ext_stall),
        .preg_ld_o          (preg_ld),
        .preg_bubble_o      (preg_bubble),
        .pc_ld_o            (pc_ld),
        .imem_read_o        (imem_read),
        .dmem_read_o        (dmem_read),
        .dmem_write_o       (dmem_write),
        .mem_stall_cnt_o    (mem_cnt),
        .ext_stall_cnt_o    (ext_cnt),
        .mem_timeout_o      (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_iseen, m_dseen;
    bit m_prev_mem, m_prev_ext;   // classification of the previous cycle
    int m_mem_cnt, m_ext_cnt, m_wd;
    bit m_to;
    bit cur_mh, cur_eh;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input rv32i_opcode op, input logic im, input logic dm, input logic [NEXT-1:0] ex);
        cw        = '0;
        cw.opcode = op;
        imem_resp = im;
        dmem_resp = dm;
        ext_stall = ex;
    endtask

    // Evaluate the expected outputs for the current cycle and compare.
    task automatic eval_and_check();
        bit            is_ld, is_st, ma, mh, eh;
        logic [NP-1:0] frozen, e_ld, e_bub;
        bit            e_pc, e_ir, e_dr, e_dw, e_to;
        @(negedge clk);
        is_ld = (cw.opcode == op_load);
        is_st = (cw.opcode == op_store);
        ma    = is_ld || is_st;
        mh    = !(imem_resp || m_iseen) || !(!ma || dmem_resp || m_dseen);
        eh    = (ext_stall != 0);
        frozen = mh ? '1 : (eh ? FRONT_MASK : '0);
        if (rst_n) begin
            e_ld  = ~frozen;
            e_bub = e_ld & (frozen << 1);
            e_pc  = !frozen[0];
            e_ir  = !m_iseen;
            e_dr  = is_ld && !m_dseen;
            e_dw  = is_st && !m_dseen;
        end else begin
            e_ld = '0; e_bub = '0; e_pc = 0; e_ir = 0; e_dr = 0; e_dw = 0;
        end
        e_to = m_to || (m_wd == TO);
        check_val("preg_ld",     64'(preg_ld),     64'(e_ld));
        check_val("preg_bubble", 64'(preg_bubble), 64'(e_bub));
        check_val("pc_ld",       64'(pc_ld),       64'(e_pc));
        check_val("imem_read",   64'(imem_read),   64'(e_ir));
        check_val("dmem_read",   64'(dmem_read),   64'(e_dr));
        check_val("dmem_write",  64'(dmem_write),  64'(e_dw));
        check_val("mem_cnt",     64'(mem_cnt),     64'(m_mem_cnt));
        check_val("ext_cnt",     64'(ext_cnt),     64'(m_ext_cnt));
        check_val("timeout",     64'(mem_timeout), 64'(e_to));
        cur_mh = mh;
        cur_eh = eh;
    endtask

    // Advance the model across one clock edge.
    task automatic tick();
        bit ma;
        @(posedge clk);
        ma = (cw.opcode == op_load) || (cw.opcode == op_store);
        if (!rst_n) begin
            m_iseen = 0; m_dseen = 0; m_prev_mem = 0; m_prev_ext = 0;
            m_mem_cnt = 0; m_ext_cnt = 0; m_wd = 0; m_to = 0;
        end else begin
            if (m_prev_mem) m_mem_cnt = (m_mem_cnt == CNT_MAX) ? CNT_MAX : m_mem_cnt + 1;
            if (m_prev_ext) m_ext_cnt = (m_ext_cnt == CNT_MAX) ? CNT_MAX : m_ext_cnt + 1;
            if (m_wd == TO) m_to = 1;
            m_wd = m_prev_mem ? ((m_wd == WD_MAX) ? WD_MAX : m_wd + 1) : 0;
            m_prev_mem = cur_mh;
            m_prev_ext = cur_eh && !cur_mh;
            if (!cur_mh && !cur_eh) begin
                m_iseen = 0;
                m_dseen = 0;
            end else begin
                if (imem_resp) m_iseen = 1;
                if (dmem_resp && ma) m_dseen = 1;
            end
        end
        #1;
    endtask

    task automatic cyc();
        eval_and_check();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(op_reg, 1'b0, 1'b0, '0);
        eval_and_check();
        check_val("rst_preg_ld", 64'(preg_ld), 64'h0);
        check_val("rst_imem_read", 64'(imem_read), 64'h0);
        tick();
        rst_n = 1'b1;
    endtask

    rv32i_opcode ops [5] = '{op_load, op_store, op_imm, op_reg, op_br};

    initial begin
        rst_n = 1'b0;
        set_in(op_reg, 1'b0, 1'b0, '0);
        cur_mh = 0;
        cur_eh = 0;
        tick();

        // Memory-port ordering: store, I-resp at 2, D-resp at 5
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 6) set_in(op_store, c == 2, c == 5, '0);
            else       set_in(op_reg, 1'b1, 1'b0, '0);
            eval_and_check();
            if (c <= 4) check_val("ord_ld_held", 64'(preg_ld), 64'h0);
            if (c == 3) begin
                check_val("ord_iread_c3", 64'(imem_read), 64'h0);
                check_val("ord_dwrite_c3", 64'(dmem_write), 64'h1);
            end
            if (c == 5) begin
                check_val("ord_ld_c5", 64'(preg_ld), 64'hf);
                check_val("ord_pc_c5", 64'(pc_ld), 64'h1);
            end
            if (c == 6) check_val("ord_iseen_clr", 64'(imem_read), 64'h1);
            if (c == 7) check_val("ord_mem_cnt", 64'(mem_cnt), 64'd5);
            tick();
        end

        // External stall alone
        do_reset();
        for (int c = 0; c < 5; c++) begin
            set_in(op_reg, 1'b1, 1'b0, (c < 3) ? 2'b01 : 2'b00);
            eval_and_check();
            if (c < 3) begin
                check_val("ext_ld", 64'(preg_ld), 64'h8);
                check_val("ext_bubble", 64'(preg_bubble), 64'h8);
                check_val("ext_pc", 64'(pc_ld), 64'h0);
            end
            if (c == 4) check_val("ext_cnt", 64'(ext_cnt), 64'd3);
            tick();
        end

        // External and memory stall overlap
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3)       set_in(op_load, 1'b1, 1'b0, 2'b10);
            else if (c == 3) set_in(op_load, 1'b1, 1'b1, 2'b00);
            else             set_in(op_reg, 1'b1, 1'b0, 2'b00);
            eval_and_check();
            if (c < 3) begin
                check_val("ovl_ld", 64'(preg_ld), 64'h0);
                check_val("ovl_bubble", 64'(preg_bubble), 64'h0);
            end
            if (c == 5) begin
                check_val("ovl_mem_cnt", 64'(mem_cnt), 64'd3);
                check_val("ovl_ext_cnt", 64'(ext_cnt), 64'd0);
            end
            tick();
        end

        // Simultaneous responses
        do_reset();
        set_in(op_load, 1'b1, 1'b1, '0);
        eval_and_check();
        check_val("sim_ld", 64'(preg_ld), 64'hf);
        tick();
        set_in(op_load, 1'b0, 1'b0, '0);
        eval_and_check();
        check_val("sim_iread", 64'(imem_read), 64'h1);
        check_val("sim_dread", 64'(dmem_read), 64'h1);
        tick();

        // Watchdog
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c < 10)       set_in(op_load, 1'b1, 1'b0, '0);
            else if (c == 10) set_in(op_load, 1'b1, 1'b1, '0);
            else              set_in(op_reg, 1'b1, 1'b0, '0);
            eval_and_check();
            if (c == 8)  check_val("wd_c8", 64'(mem_timeout), 64'h0);
            if (c == 9)  check_val("wd_c9", 64'(mem_timeout), 64'h1);
            if (c == 13) check_val("wd_sticky", 64'(mem_timeout), 64'h1);
            tick();
        end
        do_reset();
        set_in(op_reg, 1'b1, 1'b0, '0);
        eval_and_check();
        check_val("wd_rst_clr", 64'(mem_timeout), 64'h0);
        tick();

        // Reset mid-wait
        do_reset();
        set_in(op_load, 1'b1, 1'b0, '0);
        cyc();
        set_in(op_load, 1'b0, 1'b0, '0);
        eval_and_check();
        check_val("rmw_iseen", 64'(imem_read), 64'h0);
        tick();
        do_reset();
        set_in(op_reg, 1'b0, 1'b0, '0);
        eval_and_check();
        check_val("rmw_iread", 64'(imem_read), 64'h1);
        check_val("rmw_mem_cnt", 64'(mem_cnt), 64'h0);
        tick();

        // Randomized traffic, response probability varied per block
        begin
            int pct;
            pct = 30;
            for (int n = 0; n < 2000; n++) begin
                if (n % 100 == 0) pct = $urandom_range(5, 70);
                rst_n = ($urandom_range(0, 199) != 0);
                set_in(ops[$urandom_range(0, 4)],
                       $urandom_range(0, 99) < pct,
                       $urandom_range(0, 99) < pct,
                       {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)});
                cyc();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
